// File: rtl/spi_pkg.sv
// Shared SPI definitions: FSM state encoding, spcon bit positions and byte framing.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package spi_pkg;

   // Transfer sequencing states of the master
   typedef enum logic [2:0] {
      IDLE,
      SETUP,
      XFER,
      HOLD,
      GAP
   } state_t;

   // Bit positions inside the spcon control word; bits 7:3 are reserved
   localparam int CPOL_BIT = 2;
   localparam int CPHA_BIT = 1;
   localparam int SPEN_BIT = 0;

   // One byte is framed by 16 SCK edges (8 latch + 8 shift)
   localparam int            EDGE_CNT_W     = 5;
   localparam logic [EDGE_CNT_W-1:0] EDGES_PER_BYTE = 5'd16;

   // With cpha=0 the odd edges sample, with cpha=1 the even edges sample.
   function automatic logic is_latch_edge(input logic edge_odd, input logic cpha);
      return edge_odd ^ cpha;
   endfunction

endpackage

// File: rtl/spi_clkgen.sv
// SCK half-period timer: one-cycle tick every HALF_PERIOD clk cycles while enabled.
// Latency: first tick HALF_PERIOD cycles after en rises; reloads whenever en is low.
// Backpressure: none; free-running while enabled.
//
// Ports:
//   clk   system clock
//   rst_n synchronous active-low reset
//   en    run the down-counter; low holds it at the reload value
//   tick  single-cycle strobe marking the end of a half-period
module spi_clkgen #(
   parameter int HALF_PERIOD = 4
) (
   input  logic clk,
   input  logic rst_n,
   input  logic en,
   output logic tick
);

   localparam int            CW     = $clog2(HALF_PERIOD);
   localparam logic [CW-1:0] RELOAD = CW'(HALF_PERIOD - 1);

   logic [CW-1:0] cnt;

   // The counter also reloads on its own tick, so a restart from the last
   // tick of one phase straight into the next phase keeps exact spacing.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         cnt <= RELOAD;
      end else if (!en || cnt == '0) begin
         cnt <= RELOAD;
      end else begin
         cnt <= cnt - CW'(1);
      end
   end

   assign tick = en && (cnt == '0);

endmodule

// File: rtl/spi_master.sv
// Byte-wide SPI master, all four CPOL/CPHA modes, MSB first, full duplex.
// Latency: start to tr_done_m = 17*HALF_PERIOD+1 cycles; busy low after 18*HALF_PERIOD+1.
// Backpressure: start is accepted only when idle (or on the final GAP cycle); otherwise dropped.
//
// Ports:
//   clk, rst_n    system clock, synchronous active-low reset
//   data_m        byte to send, captured on an accepted start
//   spcon_m       control word {reserved[7:3], cpol, cpha, spen}, captured on an accepted start
//   start         single-cycle transfer request
//   busy          high from accepted start through the end of the inter-frame gap
//   tr_done_m     one-cycle completion pulse
//   data_r_m      received byte, updated together with tr_done_m
//   miso, mosi    serial data in / out
//   sck, ssn      SPI clock and active-low slave select
module spi_master
   import spi_pkg::*;
#(
   parameter int HALF_PERIOD = 4   // legal range 4..255
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [7:0] data_m,
   input  logic [7:0] spcon_m,
   input  logic       start,
   output logic       busy,
   output logic       tr_done_m,
   output logic [7:0] data_r_m,
   input  logic       miso,
   output logic       mosi,
   output logic       sck,
   output logic       ssn
);

   state_t                state;
   state_t                state_nxt;
   logic                  tick;
   logic                  clk_en;
   logic                  start_ok;
   logic                  accept;
   logic                  do_edge;
   logic                  do_latch;
   logic                  do_shift;
   logic                  finish;
   logic                  release_bus;
   logic                  cpha_q;
   logic [EDGE_CNT_W-1:0] edge_cnt;
   logic [EDGE_CNT_W-1:0] edge_nxt;
   logic [7:0]            tx_sr;
   logic [7:0]            rx_sr;
   logic                  spcon_unused;

   // Reserved control bits are deliberately ignored.
   assign spcon_unused = ^spcon_m[7:3];

   assign start_ok = start && spcon_m[SPEN_BIT];
   assign edge_nxt = edge_cnt + 5'd1;
   assign clk_en   = (state != IDLE);

   spi_clkgen #(
      .HALF_PERIOD (HALF_PERIOD)
   ) u_clkgen (
      .clk   (clk),
      .rst_n (rst_n),
      .en    (clk_en),
      .tick  (tick)
   );

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt   = state;
      accept      = 1'b0;
      do_edge     = 1'b0;
      finish      = 1'b0;
      release_bus = 1'b0;
      case (state)
         IDLE: begin
            if (start_ok) begin
               accept    = 1'b1;
               state_nxt = SETUP;
            end
         end
         SETUP: begin
            // End of setup is SCK edge 1.
            if (tick) begin
               do_edge   = 1'b1;
               state_nxt = XFER;
            end
         end
         XFER: begin
            if (tick) begin
               do_edge = 1'b1;
               if (edge_nxt == EDGES_PER_BYTE) begin
                  state_nxt = HOLD;
               end
            end
         end
         HOLD: begin
            if (tick) begin
               finish    = 1'b1;
               state_nxt = GAP;
            end
         end
         GAP: begin
            // The cycle busy falls is also the earliest slot for the next
            // start, so a back-to-back request keeps ssn high exactly one gap.
            if (tick) begin
               if (start_ok) begin
                  accept    = 1'b1;
                  state_nxt = SETUP;
               end else begin
                  release_bus = 1'b1;
                  state_nxt   = IDLE;
               end
            end
         end
         default: begin
            state_nxt = IDLE;
         end
      endcase
   end

   assign do_latch = do_edge && is_latch_edge(edge_nxt[0], cpha_q);
   // With cpha=0 edge 16 is a shift-phase edge but there is nothing left to drive.
   assign do_shift = do_edge && !do_latch && (edge_nxt != EDGES_PER_BYTE);

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         sck       <= 1'b0;
         ssn       <= 1'b1;
         mosi      <= 1'b0;
         busy      <= 1'b0;
         tr_done_m <= 1'b0;
         data_r_m  <= 8'h00;
         tx_sr     <= 8'h00;
         rx_sr     <= 8'h00;
         cpha_q    <= 1'b0;
         edge_cnt  <= '0;
      end else begin
         tr_done_m <= finish;
         if (accept) begin
            // sck itself carries the latched cpol: 16 toggles return it there.
            tx_sr    <= data_m;
            cpha_q   <= spcon_m[CPHA_BIT];
            sck      <= spcon_m[CPOL_BIT];
            mosi     <= data_m[7];
            ssn      <= 1'b0;
            busy     <= 1'b1;
            edge_cnt <= '0;
         end else begin
            if (state == IDLE) begin
               sck <= spcon_m[CPOL_BIT];
            end
            if (do_edge) begin
               sck      <= ~sck;
               edge_cnt <= edge_nxt;
            end
            // miso is the value present just before this edge toggles sck.
            if (do_latch) begin
               rx_sr <= {rx_sr[6:0], miso};
            end
            // cpha=0 already put bit 7 out during setup, so its first shift
            // edge drives bit 6; cpha=1 drives bit 7 on edge 1.
            if (do_shift) begin
               mosi  <= cpha_q ? tx_sr[7] : tx_sr[6];
               tx_sr <= {tx_sr[6:0], 1'b0};
            end
            if (finish) begin
               ssn      <= 1'b1;
               data_r_m <= rx_sr;
            end
            if (release_bus) begin
               busy <= 1'b0;
            end
         end
      end
   end

endmodule

// File: tb/tb_spi_master.sv
module tb_spi_master;

   localparam int H0 = 4;
   localparam int H1 = 9;

   logic       clk = 1'b0;
   always #5 clk = ~clk;

   logic       rst_n;
   logic [7:0] data_m;
   logic [7:0] spcon_m;
   logic       start;
   logic       miso;
   logic       sel;

   logic       start0, start1;
   logic       busy0, busy1, done0, done1, mosi0, mosi1, sck0, sck1, ssn0, ssn1;
   logic [7:0] dr0, dr1;

   assign start0 = start & ~sel;
   assign start1 = start & sel;

   spi_master #(.HALF_PERIOD(H0)) dut (
      .clk (clk), .rst_n (rst_n), .data_m (data_m), .spcon_m (spcon_m),
      .start (start0), .busy (busy0), .tr_done_m (done0), .data_r_m (dr0),
      .miso (miso), .mosi (mosi0), .sck (sck0), .ssn (ssn0)
   );

   spi_master #(.HALF_PERIOD(H1)) dut9 (
      .clk (clk), .rst_n (rst_n), .data_m (data_m), .spcon_m (spcon_m),
      .start (start1), .busy (busy1), .tr_done_m (done1), .data_r_m (dr1),
      .miso (miso), .mosi (mosi1), .sck (sck1), .ssn (ssn1)
   );

   logic       busy, tr_done, mosi, sck, ssn;
   logic [7:0] data_r;
   assign busy    = sel ? busy1 : busy0;
   assign tr_done = sel ? done1 : done0;
   assign mosi    = sel ? mosi1 : mosi0;
   assign sck     = sel ? sck1  : sck0;
   assign ssn     = sel ? ssn1  : ssn0;
   assign data_r  = sel ? dr1   : dr0;

   int checks = 0;
   int errors = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
      end
   endtask

   // Behavioural SPI slave, bit-indexed by edge number.
   logic [7:0] s_data;
   logic [7:0] s_rx;
   logic       s_cpha;
   int         s_edge;
   int         s_lidx;
   logic       s_sck_q;
   logic       s_ssn_q;
   bit         s_shift;

   always @(negedge clk) begin
      if (s_ssn_q && !ssn) begin
         s_edge = 0;
         s_lidx = 0;
         s_rx   = 8'h00;
         miso   = s_data[7];
      end else if (!ssn && sck !== s_sck_q) begin
         s_edge++;
         s_shift = s_cpha ? (s_edge % 2 == 1) : (s_edge % 2 == 0);
         if (s_shift) begin
            if (s_cpha && s_edge <= 15)
               miso = s_data[7 - (s_edge - 1) / 2];
            else if (!s_cpha && s_edge <= 14)
               miso = s_data[7 - s_edge / 2];
         end else if (s_lidx < 8) begin
            s_rx[7 - s_lidx] = mosi;
            s_lidx++;
         end
      end
      s_sck_q = sck;
      s_ssn_q = ssn;
   end

   // Runs one transfer; returns at the last GAP cycle (n = 18h) so a
   // following call lands its start on the cycle busy would fall.
   task automatic xfer(input int h, input logic [7:0] d, input logic [2:0] mode,
                       input logic [7:0] sd, input int poke_n, input string tag,
                       output logic [7:0] mrx, output logic [7:0] srx);
      int   first_e, last_e, edges, done_n, done_cnt, ssn_hi;
      bit   spacing_ok;
      logic sck_prev;
      first_e = 0; last_e = 0; edges = 0; done_n = 0; done_cnt = 0; ssn_hi = 0;
      spacing_ok = 1'b1;
      mrx = 8'h00;
      srx = 8'h00;
      sck_prev = sck;
      data_m  = d;
      spcon_m = {5'b00000, mode};
      s_data  = sd;
      s_cpha  = mode[1];
      start   = 1'b1;
      @(posedge clk);
      for (int n = 1; n <= 18 * h; n++) begin
         @(negedge clk);
         if (n == 1) begin
            start = 1'b0;
            check({tag, "_ssn_low"}, ssn, 1'b0);
            check({tag, "_busy_high"}, busy, 1'b1);
            check({tag, "_mosi_b7"}, mosi, d[7]);
            data_m  = ~d;
            spcon_m = {5'b10100, mode ^ 3'b110};
         end
         if (n == poke_n) start = 1'b1;
         if (n == poke_n + 1) start = 1'b0;
         if (tr_done) begin
            done_cnt++;
            if (done_n == 0) done_n = n;
         end
         if (!ssn && sck !== sck_prev) begin
            edges++;
            if (edges == 1) first_e = n;
            else if (n - last_e != h) spacing_ok = 1'b0;
            last_e = n;
         end
         sck_prev = sck;
         if (n > 17 * h && ssn) ssn_hi++;
         if (n == 17 * h + 1) begin
            mrx = data_r;
            srx = s_rx;
            spcon_m = {5'b00000, mode};
         end
      end
      check({tag, "_done_lat"}, done_n, 17 * h + 1);
      check({tag, "_done_cnt"}, done_cnt, 1);
      check({tag, "_edges"}, edges, 16);
      check({tag, "_edge1_at"}, first_e, 1 + h);
      check({tag, "_edge_spacing"}, spacing_ok, 1'b1);
      check({tag, "_ssn_gap"}, ssn_hi, h);
      check({tag, "_busy_in_gap"}, busy, 1'b1);
   endtask

   logic [7:0] mrx, srx, mrx2, srx2;
   int         cnt, edges;
   logic       sck_prev;

   initial begin
      rst_n = 1'b0; start = 1'b0; data_m = 8'h00; spcon_m = 8'h00; sel = 1'b0;
      s_data = 8'h00; s_cpha = 1'b0; s_rx = 8'h00; s_edge = 0; s_lidx = 0;
      s_sck_q = 1'b0; s_ssn_q = 1'b1; s_shift = 1'b0; miso = 1'b0;

      repeat (3) @(negedge clk);
      check("rst_sck", sck, 1'b0);
      check("rst_ssn", ssn, 1'b1);
      check("rst_mosi", mosi, 1'b0);
      check("rst_busy", busy, 1'b0);
      check("rst_done", tr_done, 1'b0);
      check("rst_data_r", data_r, 8'h00);
      rst_n = 1'b1;
      spcon_m = 8'h01;
      repeat (2) @(negedge clk);

      // Mode 0 loopback, with a stray start during the transfer
      xfer(H0, 8'hA5, 3'b001, 8'h3C, 10, "m0", mrx, srx);
      check("m0_master_rx", mrx, 8'h3C);
      check("m0_slave_rx", srx, 8'hA5);
      @(negedge clk);
      check("m0_busy_low_73", busy, 1'b0);
      check("m0_done_single", tr_done, 1'b0);

      // start with spen=0 is ignored
      spcon_m = 8'h00; data_m = 8'hFF; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      cnt = 0;
      repeat (20) begin
         @(negedge clk);
         if (busy !== 1'b0 || ssn !== 1'b1) cnt++;
      end
      check("spen0_ignored", cnt, 0);

      // Mode 3: sck idles high
      spcon_m = 8'h07;
      repeat (2) @(negedge clk);
      check("m3_idle_before", sck, 1'b1);
      xfer(H0, 8'h81, 3'b111, 8'h7E, 0, "m3", mrx, srx);
      check("m3_master_rx", mrx, 8'h7E);
      check("m3_slave_rx", srx, 8'h81);
      repeat (3) @(negedge clk);
      check("m3_idle_after", sck, 1'b1);

      // Reset at edge 7
      spcon_m = 8'h01;
      repeat (2) @(negedge clk);
      data_m = 8'h5A; s_data = 8'h99; s_cpha = 1'b0;
      sck_prev = sck;
      start = 1'b1;
      @(posedge clk);
      edges = 0;
      for (int n = 1; n <= 200 && edges < 7; n++) begin
         @(negedge clk);
         start = 1'b0;
         if (!ssn && sck !== sck_prev) edges++;
         sck_prev = sck;
      end
      check("rst_mid_edge7_reached", edges, 7);
      rst_n = 1'b0;
      @(negedge clk);
      check("rst_mid_ssn", ssn, 1'b1);
      check("rst_mid_sck", sck, 1'b0);
      check("rst_mid_busy", busy, 1'b0);
      check("rst_mid_data_r", data_r, 8'h00);
      rst_n = 1'b1;
      cnt = 0;
      repeat (100) begin
         @(negedge clk);
         if (tr_done) cnt++;
      end
      check("rst_mid_no_done", cnt, 0);
      xfer(H0, 8'hC3, 3'b001, 8'h18, 0, "post_rst", mrx, srx);
      check("post_rst_master_rx", mrx, 8'h18);
      check("post_rst_slave_rx", srx, 8'hC3);
      repeat (2) @(negedge clk);

      // Back-to-back: second start on the cycle busy would fall
      xfer(H0, 8'h12, 3'b001, 8'h34, 0, "b2b_a", mrx, srx);
      xfer(H0, 8'hED, 3'b001, 8'hCB, 0, "b2b_b", mrx2, srx2);
      check("b2b_a_slave_rx", srx, 8'h12);
      check("b2b_b_slave_rx", srx2, 8'hED);
      check("b2b_a_master_rx", mrx, 8'h34);
      check("b2b_b_master_rx", mrx2, 8'hCB);
      @(negedge clk);
      check("b2b_busy_low", busy, 1'b0);

      // HALF_PERIOD = 9, mode 1
      sel = 1'b1;
      spcon_m = 8'h03;
      repeat (3) @(negedge clk);
      xfer(H1, 8'h55, 3'b011, 8'hF0, 0, "h9", mrx, srx);
      check("h9_master_rx", mrx, 8'hF0);
      check("h9_slave_rx", srx, 8'h55);
      @(negedge clk);
      check("h9_busy_low", busy, 1'b0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/spi_master.md
# spi_master

Byte-wide SPI master that generates `sck`, `ssn` and `mosi` for the `spi_slave` on the same bus, and captures `miso`. It sits between the host-side register logic and the SPI pins. One `start` pulse runs one 8-bit full-duplex transfer, MSB first, in any of the four CPOL/CPHA modes. It reports completion with a one-cycle `tr_done_m` pulse.

## Interface
- `HALF_PERIOD`, default 4: `clk` cycles per SCK half-period. Legal range is 4..255; a value below 4 is illegal because the slave's synchronizer needs the settling time.
- `clk`  input  1  system clock, shared with `spi_slave`.
- `rst_n`  input  1  reset, synchronous and active-low.
- `data_m`  input  8  byte to transmit; sampled on the accepted `start`.
- `spcon_m`  input  8  control word. Bit 2 = cpol, bit 1 = cpha, bit 0 = spen; bits 7:3 are reserved and ignored. Sampled on the accepted `start`.
- `start`  input  1  transfer request, single-cycle pulse.
- `busy`  output  1  high from the accepted `start` through the end of GAP.
- `tr_done_m`  output  1  one-cycle pulse at end of transfer.
- `data_r_m`  output  8  received byte; updated in the same cycle as `tr_done_m`, held otherwise.
- `miso`  input  1  serial data from the slave.
- `mosi`  output  1  serial data to the slave.
- `sck`  output  1  SPI clock.
- `ssn`  output  1  slave select, active-low.

## Operation
- **Reset values:** `sck`=0, `ssn`=1, `mosi`=0, `busy`=0, `tr_done_m`=0, `data_r_m`=0, state=IDLE.
- **States:** IDLE → SETUP → XFER → HOLD → GAP → IDLE.
- **IDLE**
  - `sck` follows the registered value of `spcon_m[2]`, so the idle level is correct before a transfer.
  - `start`=1 with `spcon_m[0]`=1 is accepted: latch `data_m` into the shift register and latch cpol/cpha.
  - `start` with spen=0 is ignored.
- **SETUP:** `ssn`=0, `mosi`=bit 7, lasts HALF_PERIOD cycles.
- **XFER:** 16 SCK edges, numbered 1..16, with HALF_PERIOD cycles between edges. An internal edge counter runs 0..16.
- **cpha=0**
  - Odd edges are latch edges: shift `miso` into the receive register.
  - Even edges 2..14 are shift edges: drive bits 6..0.
  - Edge 16 drives nothing.
- **cpha=1**
  - Odd edges are shift edges: edges 1..15 drive bits 7..0.
  - Even edges are latch edges: sample `miso`.
- **Sampling rule:** `miso` is sampled in the same `clk` cycle that `sck` is toggled for a latch edge, i.e. the value present just before the edge.
- **HOLD:** after edge 16, `sck` rests at cpol for HALF_PERIOD cycles, then `ssn`→1.
- **GAP:** `ssn` stays high for HALF_PERIOD cycles so the slave's edge counter clears. `busy` drops on exit.
- **`start` while `busy`=1** is ignored and not queued.
- **Changes to `data_m`/`spcon_m` mid-transfer** have no effect.
- **`rst_n`=0 mid-transfer:** next cycle all outputs return to reset values, the partial byte is discarded, and no `tr_done_m` is issued.

## Timing
- `start` is accepted at rising edge t. With H = HALF_PERIOD:
  - t+1: `ssn`=0, `busy`=1, `mosi`=`data_m[7]`.
  - Edge k (k=1..16) at t+1+k·H.
  - t+1+17·H: `ssn`=1, `tr_done_m`=1 for exactly one cycle, `data_r_m` valid.
  - t+1+18·H: `busy`=0. The earliest next accepted `start` is in that cycle.
- Transfer length from `start` to `busy` low is 18·H+1 cycles (73 at the default).
- All outputs are registered; there are no combinational paths from inputs to outputs.

## Structure
- **Package `spi_pkg`:**
  - state enum (IDLE, SETUP, XFER, HOLD, GAP);
  - `spcon` bit-index constants (CPOL_BIT=2, CPHA_BIT=1, SPEN_BIT=0);
  - `EDGES_PER_BYTE`=16.
  - `spi_slave` is to be migrated to the same constants.
- **Sub-module `spi_clkgen`:**
  - half-period down-counter that emits a one-cycle `tick` every HALF_PERIOD cycles while enabled;
  - reloads when disabled.
- **Top level:** FSM, edge counter, TX/RX shift registers.

## Test plan
- **Mode 0, loopback with `spi_slave`:** `data_m`=0xA5, slave `data_s`=0x3C, `spcon` bits 2:0=001. Expect:
  - master `data_r_m`=0x3C;
  - slave `data_r_s`=0xA5;
  - `tr_done_m` at t+69 (H=4).
- **Mode 3 with `spi_slave`:** `data_m`=0x81, `data_s`=0x7E. Expect:
  - `sck` idle high before and after;
  - exchanged bytes correct;
  - exactly 16 `sck` edges while `ssn`=0.
- **Ignored starts:**
  - `start` pulsed at t+10 during a transfer leaves the transfer and timing unchanged;
  - `start` with spen=0 keeps `busy`=0 and `ssn`=1.
- **Reset mid-transfer:** `rst_n` low at edge 7. Expect:
  - next cycle `ssn`=1, `sck`=0, `busy`=0, `data_r_m`=0x00;
  - no `tr_done_m`;
  - a following transfer completes correctly.
- **Back-to-back:** second `start` in the cycle `busy` falls. Expect:
  - `ssn` high for exactly H cycles between transfers;
  - both bytes received correctly by the slave.
- **HALF_PERIOD=9, mode 1:** `data_m`=0x55, `data_s`=0xF0. Expect:
  - edge spacing of 9 cycles;
  - `data_r_m`=0xF0.
